// File: rtl/wmem_loader_pkg.sv
// wmem_loader_pkg: shared loader state encoding and default weight-memory geometry.
package wmem_loader_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ROW_NUM    = 6;
    localparam int DEF_ADDR_WIDTH = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE
    } state_e;
endpackage

// File: rtl/wmem_row_packer.sv
// wmem_row_packer: gathers ROW_NUM stream bytes into one row word, lane 0 in the LSBs.
module wmem_row_packer
    import wmem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROW_NUM    = DEF_ROW_NUM
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  logic                             beat_i,
    input  logic [DATA_WIDTH-1:0]            data_i,
    output logic                             row_full_o,
    output logic [DATA_WIDTH*ROW_NUM-1:0]    row_data_o
);
    localparam int LW = $clog2(ROW_NUM);
    localparam int RW = DATA_WIDTH * ROW_NUM;

    logic [LW-1:0] lane_q, lane_d;
    logic [RW-1:0] pack_q, pack_d;

    // row_data_o already contains the byte arriving this cycle, so the row is complete on its last beat
    always_comb begin
        pack_d = pack_q;
        for (int k = 0; k < ROW_NUM; k++)
            if (beat_i && lane_q == LW'(k)) pack_d[k*DATA_WIDTH +: DATA_WIDTH] = data_i;
    end

    assign row_full_o = beat_i && lane_q == LW'(ROW_NUM - 1);
    assign row_data_o = pack_d;
    assign lane_d     = (clear_i || row_full_o) ? '0 : beat_i ? lane_q + LW'(1) : lane_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q <= '0;
            pack_q <= '0;
        end else begin
            lane_q <= lane_d;
            pack_q <= clear_i ? '0 : pack_d;
        end
    end
endmodule

// File: rtl/wmem_loader.sv
// wmem_loader: packs a weight byte stream into rows and writes them to consecutive wmem addresses.
module wmem_loader
    import wmem_loader_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ROW_NUM       = DEF_ROW_NUM,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int ROW_WGT_WIDTH = DATA_WIDTH * ROW_NUM
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic [ADDR_WIDTH-1:0]    i_base_addr,
    input  logic [ADDR_WIDTH:0]      i_num_rows,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic                     o_wr_en,
    output logic [ADDR_WIDTH-1:0]    o_wr_addr,
    output logic [ROW_WGT_WIDTH-1:0] o_wr_data,
    output logic                     o_busy,
    output logic                     o_done
);
    state_e                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      base_q, base_d;
    logic [ADDR_WIDTH:0]        num_rows_q, num_rows_d;
    logic [ADDR_WIDTH:0]        row_cnt_q, row_cnt_d, row_nxt;
    logic                       wr_en_q;
    logic [ADDR_WIDTH-1:0]      wr_addr_q, wr_addr_d;
    logic [ROW_WGT_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                       clear, beat, row_full, accept_job;
    logic [ROW_WGT_WIDTH-1:0]   row_data;

    assign accept_job = state_q == ST_IDLE && i_start && !i_abort;
    assign beat       = state_q == ST_LOAD && i_valid && !i_abort;
    assign clear      = accept_job || i_abort;
    assign row_nxt    = row_cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};

    wmem_row_packer #(
        .DATA_WIDTH(DATA_WIDTH),
        .ROW_NUM   (ROW_NUM)
    ) u_packer (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .clear_i   (clear),
        .beat_i    (beat),
        .data_i    (i_data),
        .row_full_o(row_full),
        .row_data_o(row_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_start) state_d = (i_num_rows == '0) ? ST_DONE : ST_LOAD;
            ST_LOAD:  if (row_full && row_nxt == num_rows_q) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (i_abort) state_d = ST_IDLE;
    end

    assign base_d     = accept_job ? i_base_addr : base_q;
    assign num_rows_d = accept_job ? i_num_rows : num_rows_q;
    assign row_cnt_d  = clear ? '0 : row_full ? row_nxt : row_cnt_q;
    assign wr_addr_d  = row_full ? base_q + row_cnt_q[ADDR_WIDTH-1:0] : wr_addr_q;
    assign wr_data_d  = row_full ? row_data : wr_data_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            num_rows_q <= '0;
            row_cnt_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_rows_q <= num_rows_d;
            row_cnt_q  <= row_cnt_d;
            wr_en_q    <= row_full;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // an abort landing on a presented write (e.g. in FLUSH) drops that write
    assign o_wr_en   = wr_en_q && !i_abort;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;
    assign o_ready   = state_q == ST_LOAD;
    assign o_busy    = state_q != ST_IDLE;
    assign o_done    = state_q == ST_DONE;
endmodule

// File: tb/tb_wmem_loader.sv
// tb_wmem_loader: directed table vectors, corner sequences and random jobs against a row-packing model.
module tb_wmem_loader;
    localparam int DW = 8, RN = 6, AW = 7, RW = 48;

    logic          clk = 0, rst_n = 0, start = 0, abort = 0, valid = 0;
    logic [AW-1:0] base = 0;
    logic [AW:0]   nrows = 0;
    logic [DW-1:0] data = 0;
    logic          o_ready, o_wr_en, o_busy, o_done;
    logic [AW-1:0] o_wr_addr;
    logic [RW-1:0] o_wr_data;

    wmem_loader dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_base_addr(base), .i_num_rows(nrows), .i_data(data), .i_valid(valid),
        .o_ready(o_ready), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [RW-1:0] d;
        int            c;
    } wr_t;

    int          cyc = 0, rdy_cnt = 0, n_cmp = 0, n_bad = 0;
    wr_t         wq[$];
    int          acc_c[$], done_c[$];
    logic [7:0]  stim[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_wr_en) wq.push_back('{o_wr_addr, o_wr_data, cyc});
        if (valid && o_ready) acc_c.push_back(cyc);
        if (o_done) done_c.push_back(cyc);
        if (o_ready) rdy_cnt++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_q;
        wq.delete();
        acc_c.delete();
        done_c.delete();
        rdy_cnt = 0;
    endtask

    task automatic start_job(input logic [AW-1:0] b, input logic [AW:0] n);
        start = 1; base = b; nrows = n;
        tick;
        start = 0;
    endtask

    task automatic feed(input int gap_at, input int gap_len, input bit rnd_gap);
        int i = 0, g = 0, budget = 0;
        while (i < stim.size() && budget < 2000) begin
            if (g > 0) begin
                valid = 0; g--;
            end else if (rnd_gap && $urandom_range(3) == 0) valid = 0;
            else begin
                valid = 1; data = stim[i];
            end
            if (valid && o_ready) begin
                i++;
                if (i == gap_at) g = gap_len;
            end
            tick;
            budget++;
        end
        valid = 0;
        chk("feed_all", i, stim.size());
    endtask

    task automatic wait_idle(input string nm);
        int b = 0;
        while (o_busy && b < 100) begin
            tick; b++;
        end
        chk({nm, "_idle"}, o_busy, 0);
    endtask

    // expected rows built straight from the byte list: byte 6r+k lands in lane k of row r
    task automatic check_job(input string nm, input logic [AW-1:0] b, input int n);
        chk({nm, "_nwr"}, wq.size(), n);
        for (int r = 0; r < n && r < wq.size(); r++) begin
            logic [RW-1:0] exp = '0;
            logic [AW-1:0] ea = b + AW'(r);
            for (int k = 0; k < RN; k++) exp |= RW'(stim[RN*r+k]) << (DW*k);
            chk({nm, "_addr"}, wq[r].a, ea);
            chk({nm, "_data"}, wq[r].d, exp);
            if (acc_c.size() > RN*r+RN-1) chk({nm, "_wlat"}, wq[r].c - acc_c[RN*r+RN-1], 1);
        end
        chk({nm, "_ndone"}, done_c.size(), 1);
        if (done_c.size() == 1 && acc_c.size() > 0) chk({nm, "_dlat"}, done_c[0] - acc_c[$], 2);
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   rows;
        int            gap_at;
        int            gap_len;
        logic [AW-1:0] a0, a1;
        logic [RW-1:0] d0, d1;
        int            w0_lat;
    } vec_t;

    vec_t vt[3];

    initial begin
        int st_c;
        vt[0] = '{7'd5,   8'd2, 0, 0, 7'd5,   7'd6, 48'h060504030201, 48'h0C0B0A090807, 6};
        vt[1] = '{7'd5,   8'd2, 3, 3, 7'd5,   7'd6, 48'h060504030201, 48'h0C0B0A090807, 9};
        vt[2] = '{7'd127, 8'd2, 0, 0, 7'd127, 7'd0, 48'h060504030201, 48'h0C0B0A090807, 6};

        tick; tick;
        chk("rst_ready", o_ready, 0);
        chk("rst_wr_en", o_wr_en, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_addr", o_wr_addr, 0);
        chk("rst_data", o_wr_data, 0);
        rst_n = 1;
        tick;

        foreach (vt[v]) begin
            clr_q();
            stim.delete();
            for (int i = 1; i <= 12; i++) stim.push_back(8'(i));
            start_job(vt[v].base, vt[v].rows);
            feed(vt[v].gap_at, vt[v].gap_len, 0);
            wait_idle($sformatf("v%0d", v));
            chk($sformatf("v%0d_nwr", v), wq.size(), 2);
            chk($sformatf("v%0d_ndone", v), done_c.size(), 1);
            if (wq.size() >= 2 && acc_c.size() == 12) begin
                chk($sformatf("v%0d_a0", v), wq[0].a, vt[v].a0);
                chk($sformatf("v%0d_a1", v), wq[1].a, vt[v].a1);
                chk($sformatf("v%0d_d0", v), wq[0].d, vt[v].d0);
                chk($sformatf("v%0d_d1", v), wq[1].d, vt[v].d1);
                chk($sformatf("v%0d_w0lat", v), wq[0].c - acc_c[0], vt[v].w0_lat);
                if (done_c.size() == 1) chk($sformatf("v%0d_dlat", v), done_c[0] - acc_c[11], 2);
            end
        end

        // zero-row job: straight to DONE, no writes, never ready
        clr_q();
        st_c = cyc;
        start_job(7'd9, 8'd0);
        wait_idle("zero");
        tick;
        chk("zero_nwr", wq.size(), 0);
        chk("zero_ready", rdy_cnt, 0);
        chk("zero_ndone", done_c.size(), 1);
        if (done_c.size() == 1) chk("zero_dlat", done_c[0] - st_c, 1);

        // abort after row 0 plus 4 bytes of row 1 of a 3-row job
        clr_q();
        stim.delete();
        for (int i = 1; i <= 10; i++) stim.push_back(8'(i));
        start_job(7'd10, 8'd3);
        feed(0, 0, 0);
        abort = 1;
        tick;
        abort = 0;
        tick; tick;
        chk("abort_nwr", wq.size(), 1);
        chk("abort_ndone", done_c.size(), 0);
        chk("abort_busy", o_busy, 0);
        clr_q();
        stim.delete();
        for (int i = 0; i < RN; i++) stim.push_back(8'hA1 + 8'(i));
        start_job(7'd20, 8'd1);
        feed(0, 0, 0);
        wait_idle("post_abort");
        check_job("post_abort", 7'd20, 1);

        // asynchronous reset mid-row, then a fresh job with a stray start while busy
        clr_q();
        stim.delete();
        for (int i = 0; i < 3; i++) stim.push_back(8'h55 + 8'(i));
        start_job(7'd30, 8'd2);
        feed(0, 0, 0);
        rst_n = 0;
        #1;
        chk("arst_ready", o_ready, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_addr", o_wr_addr, 0);
        chk("arst_data", o_wr_data, 0);
        tick;
        chk("arst_wr_en", o_wr_en, 0);
        chk("arst_done", o_done, 0);
        rst_n = 1;
        tick;
        clr_q();
        stim.delete();
        for (int i = 0; i < RN; i++) stim.push_back(8'hB1 + 8'(i));
        start_job(7'd40, 8'd1);
        start = 1; base = 7'd99; nrows = 8'd5;
        feed(0, 0, 0);
        start = 0;
        wait_idle("post_rst");
        check_job("post_rst", 7'd40, 1);

        // random jobs with random stalls
        for (int j = 0; j < 8; j++) begin
            logic [AW-1:0] rb = AW'($urandom_range(127));
            int            rn = $urandom_range(1, 5);
            clr_q();
            stim.delete();
            for (int i = 0; i < rn*RN; i++) stim.push_back(8'($urandom));
            start_job(rb, (AW+1)'(rn));
            feed(0, 0, 1);
            wait_idle($sformatf("rnd%0d", j));
            check_job($sformatf("rnd%0d", j), rb, rn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
